sseg_scan_decoder: RTL and testbench

- Receive-side counterpart of the time-multiplexed seven-segment display driver.
- Samples the active-low anode and segment lines and waits for each digit's dwell to settle.
- Decodes the segment pattern back to a 4-bit hex value and stores it per digit position.
- Used as an in-design display monitor and as the bench-side checker for counter/debouncer demos; runs on the same 100 MHz clock as the display driver.

---
 rtl/sseg_scan_decoder.sv | 121 ++++++++++++
 tb/tb_sseg_scan_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: recovers hex digits from a time-multiplexed, active-low seven-segment bus.
// A digit is captured once its an/sseg/dp lines have held steady for SETTLE_CYC cycles.
module sseg_scan_decoder #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned STALE_CYC  = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [6:0]  sseg,
  input  logic        dp,
  output logic [31:0] hex,
  output logic [7:0]  dig_valid,
  output logic [7:0]  blank,
  output logic [7:0]  dp_out,
  output logic        frame_done,
  output logic        pat_err,
  output logic        an_err
);
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] sseg;
    logic       dp;
  } bus_t;

  bus_t        in_q, prev_q;
  logic [15:0] stab_cnt;
  logic [31:0] stale_cnt;
  logic [7:0]  seen, seen_nxt, sel;
  logic [4:0]  dec;
  logic        stable, capture, single, multi, cap_one, hit, is_blank, expire;

  // {hit, value}; hit=0 for anything outside the 16-glyph set
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  assign stable   = (in_q == prev_q);
  // the edge that moves the count to SETTLE_CYC-1 is the single capture edge of a run
  assign capture  = stable && (stab_cnt == 16'(SETTLE_CYC - 2));
  assign sel      = ~in_q.an;
  assign single   = $onehot(sel);
  assign multi    = !single && (in_q.an != 8'hFF);
  assign cap_one  = capture && single;
  assign dec      = decode(in_q.sseg);
  assign hit      = dec[4];
  assign is_blank = (in_q.sseg == 7'h7F);
  assign seen_nxt = seen | sel;
  assign expire   = (STALE_CYC != 0) && !cap_one && (stale_cnt == 32'(STALE_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q       <= '1;
      prev_q     <= '1;
      stab_cnt   <= '0;
      stale_cnt  <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      pat_err    <= 1'b0;
      an_err     <= 1'b0;
    end else begin
      in_q   <= '{an: an, sseg: sseg, dp: dp};
      prev_q <= in_q;
      if (!stable)                             stab_cnt <= '0;
      else if (stab_cnt != 16'(SETTLE_CYC)) stab_cnt <= stab_cnt + 16'd1;
      frame_done <= 1'b0;
      pat_err    <= cap_one && !hit && !is_blank;
      an_err     <= capture && multi;
      if (cap_one) begin
        stale_cnt <= '0;
        if (seen_nxt == 8'hFF) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_nxt;
        end
      end else begin
        if (expire) seen <= '0;
        if (stale_cnt != 32'(STALE_CYC)) stale_cnt <= stale_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex       <= '0;
      dig_valid <= '0;
      blank     <= '0;
      dp_out    <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (cap_one && sel[i]) begin
          dp_out[i]    <= ~in_q.dp;
          blank[i]     <= is_blank;
          dig_valid[i] <= hit;
          if (hit) hex[4*i +: 4] <= dec[3:0];
        end else if (expire) begin
          dig_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed vector table, corner sequences, and random
// dwells checked every cycle against a run-length based reference model.
module tb_sseg_scan_decoder;
  localparam int SETTLE = 16;
  localparam int STALE  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic [31:0] hex;
  logic [7:0]  dig_valid, blank, dp_out;
  logic        frame_done, pat_err, an_err;

  sseg_scan_decoder #(.SETTLE_CYC(SETTLE), .STALE_CYC(STALE)) dut (
    .clk(clk), .rst(rst), .an(an), .sseg(sseg), .dp(dp),
    .hex(hex), .dig_valid(dig_valid), .blank(blank), .dp_out(dp_out),
    .frame_done(frame_done), .pat_err(pat_err), .an_err(an_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int n_fd = 0, n_pe = 0, n_ae = 0, n_both = 0;
  logic [6:0] seg_tab [16];

  // reference model: run of identical registered samples, slot arrays, frame mask
  logic [15:0] m_reg, run_val;
  int          run_len, since;
  logic [3:0]  m_hex [8];
  logic [7:0]  m_valid, m_blank, m_dp, m_seen;
  logic        m_fd, m_pe, m_ae;

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    int          n;
    logic [31:0] hex;
    logic [7:0]  valid, blank, dpo;
  } row_t;
  row_t rows [$];

  function automatic logic [31:0] m_hex_flat();
    logic [31:0] f;
    for (int i = 0; i < 8; i++) f[4*i +: 4] = m_hex[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] a, input logic [6:0] s, input logic d);
    logic [15:0] v;
    int lows, idx, val;
    logic cap_single;
    m_fd = 1'b0; m_pe = 1'b0; m_ae = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_hex[i] = 4'h0;
      m_valid = '0; m_blank = '0; m_dp = '0; m_seen = '0;
      m_reg = '1; run_val = '1; run_len = 1; since = 0;
      return;
    end
    v = m_reg;
    if (v == run_val) run_len++;
    else begin run_val = v; run_len = 1; end
    lows = 0; idx = 0; cap_single = 1'b0;
    for (int i = 0; i < 8; i++) if (!v[8+i]) begin lows++; idx = i; end
    if (run_len == SETTLE) begin
      if (lows == 1) begin
        cap_single = 1'b1;
        val = -1;
        for (int k = 0; k < 16; k++) if (seg_tab[k] == v[7:1]) val = k;
        m_dp[idx] = ~v[0];
        if (val >= 0) begin
          m_hex[idx] = 4'(val); m_valid[idx] = 1'b1; m_blank[idx] = 1'b0;
        end else if (v[7:1] == 7'h7F) begin
          m_valid[idx] = 1'b0; m_blank[idx] = 1'b1;
        end else begin
          m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; m_pe = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin m_fd = 1'b1; m_seen = '0; end
      end else if (lows > 1) begin
        m_ae = 1'b1;
      end
    end
    if (cap_single) since = 0;
    else begin
      since++;
      if (since == STALE) begin m_valid = '0; m_seen = '0; end
    end
    m_reg = {a, s, d};
  endtask

  task automatic tick(input logic r, input logic [7:0] a, input logic [6:0] s, input logic d);
    rst = r; an = a; sseg = s; dp = d;
    @(posedge clk);
    model_step(r, a, s, d);
    #1;
    if (frame_done) n_fd++;
    if (pat_err) n_pe++;
    if (an_err) n_ae++;
    if (frame_done && pat_err) n_both++;
    check("model", {5'b0, hex, dig_valid, blank, dp_out, frame_done, pat_err, an_err},
          {5'b0, m_hex_flat(), m_valid, m_blank, m_dp, m_fd, m_pe, m_ae});
  endtask

  task automatic dwell(input int n, input logic [7:0] a, input logic [6:0] s, input logic d);
    for (int i = 0; i < n; i++) tick(1'b0, a, s, d);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    rows.push_back('{8'hFE, 7'b0100100, 1'b1, 20, 32'h00000002, 8'h01, 8'h00, 8'h00});
    rows.push_back('{8'hFE, 7'b1111001, 1'b1, 20, 32'h00000001, 8'h01, 8'h00, 8'h00});
    rows.push_back('{8'hFD, 7'b0100100, 1'b1, 20, 32'h00000021, 8'h03, 8'h00, 8'h00});
    rows.push_back('{8'hFB, 7'b0110000, 1'b1, 20, 32'h00000321, 8'h07, 8'h00, 8'h00});
    rows.push_back('{8'hF7, 7'b0011001, 1'b1, 20, 32'h00004321, 8'h0F, 8'h00, 8'h00});
    rows.push_back('{8'hEF, 7'b0010010, 1'b1, 20, 32'h00054321, 8'h1F, 8'h00, 8'h00});
    rows.push_back('{8'hDF, 7'b0000010, 1'b1, 20, 32'h00654321, 8'h3F, 8'h00, 8'h00});
    rows.push_back('{8'hBF, 7'b1111000, 1'b1, 20, 32'h07654321, 8'h7F, 8'h00, 8'h00});
    rows.push_back('{8'h7F, 7'b0000000, 1'b1, 20, 32'h87654321, 8'hFF, 8'h00, 8'h00});
    rows.push_back('{8'hF7, 7'b1010101, 1'b1, 20, 32'h87654321, 8'hF7, 8'h00, 8'h00});
    rows.push_back('{8'hF7, 7'b1111111, 1'b1, 20, 32'h87654321, 8'hF7, 8'h08, 8'h00});
    rows.push_back('{8'hFD, 7'b0010000, 1'b1, 10, 32'h87654321, 8'hF7, 8'h08, 8'h00});
    rows.push_back('{8'hFB, 7'b0000010, 1'b0, 16, 32'h87654321, 8'hF7, 8'h08, 8'h00});
    rows.push_back('{8'hFB, 7'b0000010, 1'b0,  4, 32'h87654621, 8'hF7, 8'h08, 8'h04});
    rows.push_back('{8'hFC, 7'b0000000, 1'b1, 20, 32'h87654621, 8'hF7, 8'h08, 8'h04});

    tick(1'b1, 8'hFF, 7'h7F, 1'b1);
    tick(1'b1, 8'hFF, 7'h7F, 1'b1);
    check("reset_state", {29'b0, hex, dig_valid, blank, dp_out, frame_done, pat_err, an_err}, 64'h0);

    foreach (rows[r]) begin
      dwell(rows[r].n, rows[r].an, rows[r].sseg, rows[r].dp);
      check($sformatf("row%0d", r), {8'b0, hex, dig_valid, blank, dp_out},
            {8'b0, rows[r].hex, rows[r].valid, rows[r].blank, rows[r].dpo});
    end
    check("frame_done_count", 64'(n_fd), 64'd1);
    check("pat_err_count", 64'(n_pe), 64'd1);
    check("an_err_count", 64'(n_ae), 64'd1);

    // reset in the middle of a dwell, then a full run is needed again
    dwell(10, 8'hFE, 7'b0000000, 1'b1);
    tick(1'b1, 8'hFE, 7'b0000000, 1'b1);
    check("rst_mid_dwell", {29'b0, hex, dig_valid, blank, dp_out, frame_done, pat_err, an_err}, 64'h0);
    dwell(16, 8'hFE, 7'b0000000, 1'b1);
    check("no_early_capture", 64'(dig_valid), 64'h00);
    dwell(1, 8'hFE, 7'b0000000, 1'b1);
    check("capture_after_rst", {32'b0, hex[3:0], dig_valid}, {32'b0, 4'h8, 8'h01});

    // stale expiry keeps hex and dp_out
    dwell(20, 8'hFE, 7'b1111001, 1'b0);
    check("stale_pre", {8'b0, hex, dig_valid, dp_out}, {8'b0, 32'h00000001, 8'h01, 8'h01});
    dwell(96, 8'hFF, 7'h7F, 1'b1);
    check("stale_not_yet", 64'(dig_valid), 64'h01);
    dwell(1, 8'hFF, 7'h7F, 1'b1);
    check("stale_expired", {8'b0, hex, dig_valid, dp_out}, {8'b0, 32'h00000001, 8'h00, 8'h01});

    // last position of a frame undecodable: pat_err and frame_done together
    n_both = 0;
    for (int i = 0; i < 7; i++) dwell(20, ~(8'h01 << i), seg_tab[i], 1'b1);
    dwell(20, 8'h7F, 7'b1010101, 1'b1);
    check("pat_err_with_frame_done", 64'(n_both), 64'd1);

    for (int k = 0; k < 250; k++) begin
      logic [7:0] a;
      logic [6:0] s;
      int q;
      q = $urandom_range(0, 9);
      if (q < 7)       a = ~(8'h01 << $urandom_range(0, 7));
      else if (q == 7) a = 8'hFF;
      else             a = 8'($urandom) & 8'hFC;
      q = $urandom_range(0, 9);
      if (q < 7)       s = seg_tab[$urandom_range(0, 15)];
      else if (q == 7) s = 7'h7F;
      else             s = 7'($urandom);
      if ($urandom_range(0, 49) == 0) tick(1'b1, a, s, 1'b1);
      dwell($urandom_range(1, 24), a, s, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
